// File: rtl/ram_w256b8_master.sv
// Sequencing initiator for the 256x8 banked RAM: single read/write, pattern fill
// and read-checksum bursts, one response per command over valid/ready.
module ram_w256b8_master #(
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Cmd_Valid,
  output logic              Cmd_Ready,
  input  logic [1:0]        Cmd_Op,
  input  logic [ADDR_W-1:0] Cmd_Addr,
  input  logic [ADDR_W-1:0] Cmd_Len,
  input  logic [DATA_W-1:0] Cmd_Data,
  output logic              Rsp_Valid,
  input  logic              Rsp_Ready,
  output logic [DATA_W-1:0] Rsp_Data,
  output logic              Busy,
  output logic              Mem_EN,
  output logic              Mem_RW,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [DATA_W-1:0] Mem_Data_In,
  input  logic [DATA_W-1:0] Mem_Data_Out
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD      = 3'd2,
    S_RD_WAIT = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  localparam logic [1:0] OP_RD     = 2'b00;
  localparam logic [1:0] OP_WR     = 2'b01;
  localparam logic [1:0] OP_FILL   = 2'b10;
  localparam logic [1:0] OP_CSUM   = 2'b11;
  localparam logic [1:0] WAIT_LAST = 2'(READ_LAT - 1);

  state_t              state_r, state_nx;
  logic [1:0]          op_r, op_nx;
  logic [ADDR_W-1:0]   len_r, len_nx;
  logic [ADDR_W-1:0]   beat_r, beat_nx;
  logic [1:0]          wait_r, wait_nx;
  logic [DATA_W-1:0]   csum_r, csum_nx;
  logic                mem_en_r, mem_en_nx;
  logic                mem_rw_r, mem_rw_nx;
  logic [ADDR_W-1:0]   mem_addr_r, mem_addr_nx;
  logic [DATA_W-1:0]   mem_din_r, mem_din_nx;
  logic                rsp_valid_r, rsp_valid_nx;
  logic [DATA_W-1:0]   rsp_data_r, rsp_data_nx;
  logic                busy_r, busy_nx;
  logic                cmd_ready_r, cmd_ready_nx;

  logic                accept_s;
  logic                beat_last_s;
  logic                wait_done_s;
  logic [DATA_W-1:0]   sum_s;

  assign accept_s    = Cmd_Valid && cmd_ready_r && (state_r == S_IDLE);
  assign beat_last_s = (beat_r == len_r);
  assign wait_done_s = (wait_r == WAIT_LAST);
  assign sum_s       = csum_r + Mem_Data_Out;

  assign Cmd_Ready   = cmd_ready_r;
  assign Rsp_Valid   = rsp_valid_r;
  assign Rsp_Data    = rsp_data_r;
  assign Busy        = busy_r;
  assign Mem_EN      = mem_en_r;
  assign Mem_RW      = mem_rw_r;
  assign Mem_Address = mem_addr_r;
  assign Mem_Data_In = mem_din_r;

  // State, datapath and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      op_r        <= 2'b00;
      len_r       <= {ADDR_W{1'b0}};
      beat_r      <= {ADDR_W{1'b0}};
      wait_r      <= 2'b00;
      csum_r      <= {DATA_W{1'b0}};
      mem_en_r    <= 1'b0;
      mem_rw_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_din_r   <= {DATA_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {DATA_W{1'b0}};
      busy_r      <= 1'b0;
      cmd_ready_r <= 1'b1;
    end else begin
      state_r     <= state_nx;
      op_r        <= op_nx;
      len_r       <= len_nx;
      beat_r      <= beat_nx;
      wait_r      <= wait_nx;
      csum_r      <= csum_nx;
      mem_en_r    <= mem_en_nx;
      mem_rw_r    <= mem_rw_nx;
      mem_addr_r  <= mem_addr_nx;
      mem_din_r   <= mem_din_nx;
      rsp_valid_r <= rsp_valid_nx;
      rsp_data_r  <= rsp_data_nx;
      busy_r      <= busy_nx;
      cmd_ready_r <= cmd_ready_nx;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          if ((Cmd_Op == OP_WR) || (Cmd_Op == OP_FILL)) state_nx = S_WR;
          else                                          state_nx = S_RD;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_WR: begin
        if (beat_last_s) state_nx = S_RESP;
        else             state_nx = S_WR;
      end
      S_RD:    state_nx = S_RD_WAIT;
      S_RD_WAIT: begin
        if (wait_done_s) begin
          if (beat_last_s) state_nx = S_RESP;
          else             state_nx = S_RD;
        end else begin
          state_nx = S_RD_WAIT;
        end
      end
      S_RESP: begin
        if (Rsp_Ready) state_nx = S_IDLE;
        else           state_nx = S_RESP;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Next values of datapath and outputs; outputs are a function of the next state
  // so they are flop-driven yet line up with the state they belong to.
  always_comb begin
    op_nx        = op_r;
    len_nx       = len_r;
    beat_nx      = beat_r;
    wait_nx      = wait_r;
    csum_nx      = csum_r;
    mem_addr_nx  = mem_addr_r;
    mem_din_nx   = mem_din_r;
    rsp_data_nx  = rsp_data_r;
    mem_en_nx    = (state_nx == S_WR) || (state_nx == S_RD);
    mem_rw_nx    = (state_nx == S_WR);
    rsp_valid_nx = (state_nx == S_RESP);
    busy_nx      = (state_nx != S_IDLE);
    cmd_ready_nx = (state_nx == S_IDLE);
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          op_nx       = Cmd_Op;
          // single ops run exactly one beat regardless of Cmd_Len
          len_nx      = Cmd_Op[1] ? Cmd_Len : {ADDR_W{1'b0}};
          beat_nx     = {ADDR_W{1'b0}};
          wait_nx     = 2'b00;
          csum_nx     = {DATA_W{1'b0}};
          mem_addr_nx = Cmd_Addr;
          if ((Cmd_Op == OP_WR) || (Cmd_Op == OP_FILL)) mem_din_nx = Cmd_Data;
          else                                          mem_din_nx = mem_din_r;
        end else begin
          op_nx = op_r;
        end
      end
      S_WR: begin
        if (beat_last_s) begin
          rsp_data_nx = mem_din_r;
        end else begin
          beat_nx     = beat_r + ADDR_W'(1);
          mem_addr_nx = mem_addr_r + ADDR_W'(1);
          mem_din_nx  = mem_din_r + DATA_W'(1);
        end
      end
      S_RD: wait_nx = 2'b00;
      S_RD_WAIT: begin
        if (wait_done_s) begin
          csum_nx = sum_s;
          wait_nx = 2'b00;
          if (beat_last_s) begin
            rsp_data_nx = (op_r == OP_CSUM) ? sum_s : Mem_Data_Out;
          end else begin
            beat_nx     = beat_r + ADDR_W'(1);
            mem_addr_nx = mem_addr_r + ADDR_W'(1);
          end
        end else begin
          wait_nx = wait_r + 2'd1;
        end
      end
      S_RESP:  rsp_data_nx = rsp_data_r;
      default: op_nx = op_r;
    endcase
  end

endmodule

// File: tb/tb_ram_w256b8_master.sv
// Directed bench for ram_w256b8_master: READ_LAT=1 instance with a RAM model,
// plus a READ_LAT=3 instance for the latency build.
module tb_ram_w256b8_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       cmd_valid, cmd_valid3, rsp_ready, rsp_ready3;
  logic [1:0] cmd_op;
  logic [7:0] cmd_addr, cmd_len, cmd_data;

  logic       cmd_ready, rsp_valid, busy, mem_en, mem_rw;
  logic [7:0] rsp_data, mem_address, mem_data_in, mem_data_out;
  logic       cmd_ready3, rsp_valid3, busy3, mem_en3, mem_rw3;
  logic [7:0] rsp_data3, mem_address3, mem_data_in3, mem_data_out3;

  ram_w256b8_master #(.READ_LAT(1), .ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .Cmd_Valid(cmd_valid), .Cmd_Ready(cmd_ready), .Cmd_Op(cmd_op),
    .Cmd_Addr(cmd_addr), .Cmd_Len(cmd_len), .Cmd_Data(cmd_data),
    .Rsp_Valid(rsp_valid), .Rsp_Ready(rsp_ready), .Rsp_Data(rsp_data), .Busy(busy),
    .Mem_EN(mem_en), .Mem_RW(mem_rw), .Mem_Address(mem_address),
    .Mem_Data_In(mem_data_in), .Mem_Data_Out(mem_data_out)
  );

  ram_w256b8_master #(.READ_LAT(3), .ADDR_W(8), .DATA_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .Cmd_Valid(cmd_valid3), .Cmd_Ready(cmd_ready3), .Cmd_Op(cmd_op),
    .Cmd_Addr(cmd_addr), .Cmd_Len(cmd_len), .Cmd_Data(cmd_data),
    .Rsp_Valid(rsp_valid3), .Rsp_Ready(rsp_ready3), .Rsp_Data(rsp_data3), .Busy(busy3),
    .Mem_EN(mem_en3), .Mem_RW(mem_rw3), .Mem_Address(mem_address3),
    .Mem_Data_In(mem_data_in3), .Mem_Data_Out(mem_data_out3)
  );

  // RAM models: read data appears READ_LAT cycles after the access cycle.
  logic [7:0] mem  [256];
  logic [7:0] mem3 [256];
  logic [7:0] rd_q;
  logic [7:0] rd3_q [3];
  int         wr_cnt  = 0;
  int         en_cnt3 = 0;

  always @(posedge clk) begin
    if (mem_en && mem_rw)  mem[mem_address] <= mem_data_in;
    if (mem_en && !mem_rw) rd_q <= mem[mem_address];
    if (mem_en && mem_rw)  wr_cnt <= wr_cnt + 1;
  end
  assign mem_data_out = rd_q;

  always @(posedge clk) begin
    if (mem_en3 && mem_rw3)  mem3[mem_address3] <= mem_data_in3;
    if (mem_en3 && !mem_rw3) rd3_q[0] <= mem3[mem_address3];
    rd3_q[1] <= rd3_q[0];
    rd3_q[2] <= rd3_q[1];
    if (mem_en3) en_cnt3 <= en_cnt3 + 1;
  end
  assign mem_data_out3 = rd3_q[2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command and collect its response; lat = edges after the accepting
  // edge until Rsp_Valid is seen. Entered and left at a falling edge.
  task automatic run_cmd(input bit sel, input logic [1:0] op, input logic [7:0] addr,
                         input logic [7:0] len, input logic [7:0] data,
                         output logic [7:0] rsp, output int lat);
    int guard = 0;
    while (!(sel ? cmd_ready3 : cmd_ready) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_data = data;
    if (sel) cmd_valid3 = 1'b1; else cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_valid3 = 1'b0;
    chk("busy_after_accept", 32'(sel ? busy3 : busy), 32'd1);
    chk("ready_after_accept", 32'(sel ? cmd_ready3 : cmd_ready), 32'd0);
    lat = 0;
    while (!(sel ? rsp_valid3 : rsp_valid) && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    rsp = sel ? rsp_data3 : rsp_data;
    if (sel) rsp_ready3 = 1'b1; else rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0; rsp_ready3 = 1'b0;
    chk("ready_after_rsp", 32'(sel ? cmd_ready3 : cmd_ready), 32'd1);
    chk("busy_after_rsp", 32'(sel ? busy3 : busy), 32'd0);
    chk("valid_after_rsp", 32'(sel ? rsp_valid3 : rsp_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] rsp;
    int lat, w0, e0, guard;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_valid3 = 1'b0; rsp_ready = 1'b0; rsp_ready3 = 1'b0;
    cmd_op = 2'b00; cmd_addr = 8'h00; cmd_len = 8'h00; cmd_data = 8'h00;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_rw", 32'(mem_rw), 32'd0);
    chk("rst_mem_addr", 32'(mem_address), 32'h00);
    chk("rst_mem_din", 32'(mem_data_in), 32'h00);
    chk("rst_rsp_data", 32'(rsp_data), 32'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // full-memory fill: mem[i] = i, 256 write cycles, response = last value 0xFF
    w0 = wr_cnt;
    run_cmd(1'b0, 2'b10, 8'h00, 8'hFF, 8'h00, rsp, lat);
    chk("full_fill_rsp", 32'(rsp), 32'hFF);
    chk("full_fill_lat", 32'(lat), 32'd256);
    chk("full_fill_writes", 32'(wr_cnt - w0), 32'd256);

    // full checksum: sum 0..255 mod 256 = 0x80; 256 beats of 2 cycles
    run_cmd(1'b0, 2'b11, 8'h00, 8'hFF, 8'h00, rsp, lat);
    chk("full_csum_rsp", 32'(rsp), 32'h80);
    chk("full_csum_lat", 32'(lat), 32'd512);

    // single write (Cmd_Len must be ignored) then read back
    w0 = wr_cnt;
    run_cmd(1'b0, 2'b01, 8'h5A, 8'h07, 8'h3C, rsp, lat);
    chk("wr_rsp", 32'(rsp), 32'h3C);
    chk("wr_lat", 32'(lat), 32'd1);
    chk("wr_strobes", 32'(wr_cnt - w0), 32'd1);
    chk("wr_mem", 32'(mem[8'h5A]), 32'h3C);
    run_cmd(1'b0, 2'b00, 8'h5A, 8'h07, 8'h00, rsp, lat);
    chk("rd_rsp", 32'(rsp), 32'h3C);
    chk("rd_lat", 32'(lat), 32'd2);

    // wrap fill FE..01 with 01..04, neighbours untouched, then checksum 0x0A
    run_cmd(1'b0, 2'b10, 8'hFE, 8'h03, 8'h01, rsp, lat);
    chk("wrap_fill_rsp", 32'(rsp), 32'h04);
    chk("wrap_fill_lat", 32'(lat), 32'd4);
    chk("wrap_mem_fe", 32'(mem[8'hFE]), 32'h01);
    chk("wrap_mem_ff", 32'(mem[8'hFF]), 32'h02);
    chk("wrap_mem_00", 32'(mem[8'h00]), 32'h03);
    chk("wrap_mem_01", 32'(mem[8'h01]), 32'h04);
    chk("wrap_mem_02", 32'(mem[8'h02]), 32'h02);
    chk("wrap_mem_fd", 32'(mem[8'hFD]), 32'hFD);
    run_cmd(1'b0, 2'b11, 8'hFE, 8'h03, 8'h00, rsp, lat);
    chk("wrap_csum_rsp", 32'(rsp), 32'h0A);
    chk("wrap_csum_lat", 32'(lat), 32'd8);

    // response backpressure with a competing command
    cmd_op = 2'b00; cmd_addr = 8'h10; cmd_len = 8'h00; cmd_data = 8'h00;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("bp_valid_seen", 32'(rsp_valid), 32'd1);
    w0 = wr_cnt;
    cmd_op = 2'b01; cmd_addr = 8'h20; cmd_data = 8'hAA; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_data", 32'(rsp_data), 32'h10);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_ready_after", 32'(cmd_ready), 32'd1);
    chk("bp_no_write", 32'(wr_cnt - w0), 32'd0);
    run_cmd(1'b0, 2'b00, 8'h20, 8'h00, 8'h00, rsp, lat);
    chk("bp_mem_20", 32'(rsp), 32'h20);

    // READ_LAT=3 instance: read responds 4 edges after accept, one enable cycle
    run_cmd(1'b1, 2'b01, 8'h12, 8'h00, 8'h77, rsp, lat);
    chk("rl3_wr_rsp", 32'(rsp), 32'h77);
    e0 = en_cnt3;
    run_cmd(1'b1, 2'b00, 8'h12, 8'h00, 8'h00, rsp, lat);
    chk("rl3_rd_rsp", 32'(rsp), 32'h77);
    chk("rl3_rd_lat", 32'(lat), 32'd4);
    chk("rl3_en_cycles", 32'(en_cnt3 - e0), 32'd1);

    // reset at beat 10 of a Len=0x3F fill from 0x40, seed 0xA0
    cmd_op = 2'b10; cmd_addr = 8'h40; cmd_len = 8'h3F; cmd_data = 8'hA0;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_beat10_addr", 32'(mem_address), 32'h4A);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_cmd(1'b0, 2'b00, 8'h49, 8'h00, 8'h00, rsp, lat);
    chk("mid_rd_49", 32'(rsp), 32'hA9);
    run_cmd(1'b0, 2'b00, 8'h4A, 8'h00, 8'h00, rsp, lat);
    chk("mid_rd_4a", 32'(rsp), 32'h4A);
    run_cmd(1'b0, 2'b00, 8'h4B, 8'h00, 8'h00, rsp, lat);
    chk("mid_rd_4b", 32'(rsp), 32'h4B);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
